mac_t_frame_packer: RTL and testbench

MAC_T_FRAME_PACKER -- requirements
Module: mac_t_frame_packer

---
 rtl/mac_t_frame_packer.sv | 135 +++++++++++++
 tb/tb_mac_t_frame_packer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_t_frame_packer.sv
// Packs a byte stream into data-FIFO writes plus one pointer word per frame.
// Short frames are zero-padded to MIN_LEN; long frames are truncated at MAX_LEN.
module mac_t_frame_packer #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514
) (
  input  logic        sys_clk,
  input  logic        rst_sys,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        data_fifo_wr,
  output logic [7:0]  data_fifo_dout,
  input  logic [11:0] data_fifo_free,
  output logic        ptr_fifo_wr,
  output logic [15:0] ptr_fifo_dout,
  input  logic        ptr_fifo_full,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_trunc
);

  localparam logic [11:0] MAX_FREE = 12'(MAX_LEN);
  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    DATA = 5'b00010,
    PAD  = 5'b00100,
    DISC = 5'b01000,
    PTR  = 5'b10000
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] len_q, len_d, len_inc;
  logic        trunc_q, trunc_d;
  logic        dwr_q, dwr_d;
  logic [7:0]  dout_q, dout_d;
  logic        pwr_q, pwr_d;
  logic [15:0] pdout_q, pdout_d;
  logic [15:0] frames_q, frames_d;
  logic [15:0] ntrunc_q, ntrunc_d;
  logic        accept;

  assign in_ready = (state_q == DATA) || (state_q == DISC);
  assign accept   = in_valid && in_ready;
  assign len_inc  = len_q + 11'd1;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    trunc_d  = trunc_q;
    dwr_d    = 1'b0;
    dout_d   = dout_q;
    pwr_d    = 1'b0;
    pdout_d  = pdout_q;
    frames_d = frames_q;
    ntrunc_d = ntrunc_q;
    unique case (state_q)
      IDLE: begin
        len_d   = '0;
        trunc_d = 1'b0;
        // Reserve room for a whole frame up front so DATA never stalls.
        if (data_fifo_free >= MAX_FREE && !ptr_fifo_full)
          state_d = DATA;
      end
      DATA: begin
        if (accept) begin
          dwr_d  = 1'b1;
          dout_d = in_data;
          len_d  = len_inc;
          if (in_last)
            state_d = (len_inc < MIN_L) ? PAD : PTR;
          else if (len_inc == MAX_L) begin
            trunc_d = 1'b1;
            state_d = DISC;
          end
        end
      end
      PAD: begin
        dwr_d  = 1'b1;
        dout_d = 8'h00;
        len_d  = len_inc;
        if (len_inc >= MIN_L)
          state_d = PTR;
      end
      DISC: begin
        if (accept && in_last)
          state_d = PTR;
      end
      PTR: begin
        pwr_d    = 1'b1;
        pdout_d  = {trunc_q, 4'b0000, len_q};
        frames_d = frames_q + 16'd1;
        if (trunc_q)
          ntrunc_d = ntrunc_q + 16'd1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst_sys) begin
      state_q  <= IDLE;
      len_q    <= '0;
      trunc_q  <= 1'b0;
      dwr_q    <= 1'b0;
      dout_q   <= '0;
      pwr_q    <= 1'b0;
      pdout_q  <= '0;
      frames_q <= '0;
      ntrunc_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      trunc_q  <= trunc_d;
      dwr_q    <= dwr_d;
      dout_q   <= dout_d;
      pwr_q    <= pwr_d;
      pdout_q  <= pdout_d;
      frames_q <= frames_d;
      ntrunc_q <= ntrunc_d;
    end
  end

  assign data_fifo_wr   = dwr_q;
  assign data_fifo_dout = dout_q;
  assign ptr_fifo_wr    = pwr_q;
  assign ptr_fifo_dout  = pdout_q;
  assign stat_frames    = frames_q;
  assign stat_trunc     = ntrunc_q;

endmodule

// File: tb/tb_mac_t_frame_packer.sv
// Directed bench for mac_t_frame_packer: frame table plus stall/reset sequences.
// Writes are collected at the falling edge and compared against table values.
module tb_mac_t_frame_packer;

  logic        sys_clk = 1'b0;
  logic        rst_sys;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        data_fifo_wr;
  logic [7:0]  data_fifo_dout;
  logic [11:0] data_fifo_free;
  logic        ptr_fifo_wr;
  logic [15:0] ptr_fifo_dout;
  logic        ptr_fifo_full;
  logic [15:0] stat_frames;
  logic [15:0] stat_trunc;

  mac_t_frame_packer dut (
    .sys_clk       (sys_clk),
    .rst_sys       (rst_sys),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .data_fifo_wr  (data_fifo_wr),
    .data_fifo_dout(data_fifo_dout),
    .data_fifo_free(data_fifo_free),
    .ptr_fifo_wr   (ptr_fifo_wr),
    .ptr_fifo_dout (ptr_fifo_dout),
    .ptr_fifo_full (ptr_fifo_full),
    .stat_frames   (stat_frames),
    .stat_trunc    (stat_trunc)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          n;
    bit          gap;
    int          exp_wr;
    logic [15:0] exp_ptr;
  } vec_t;

  vec_t        vecs[9];
  logic [7:0]  data_q[$];
  logic [15:0] ptr_q[$];
  int          cyc = 0;
  int          last_dcyc = 0;
  int          pcyc = 0;
  int          checks = 0;
  int          fails = 0;
  int          exp_frames = 0;
  int          exp_trunc = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (data_fifo_wr) begin
      data_q.push_back(data_fifo_dout);
      last_dcyc <= cyc;
    end
    if (ptr_fifo_wr) begin
      ptr_q.push_back(ptr_fifo_dout);
      pcyc <= cyc;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int b;
    b = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && b < 5000) begin
      @(negedge sys_clk);
      b++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    @(negedge sys_clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_sys = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge sys_clk);
    rst_sys = 1'b0;
    exp_frames = 0;
    exp_trunc  = 0;
  endtask

  task automatic run_frame(input int n, input bit gap, input int exp_wr,
                           input logic [15:0] exp_ptr);
    int b;
    int mism;
    logic [7:0] e;
    data_q.delete();
    ptr_q.delete();
    for (int i = 0; i < n; i++) begin
      if (gap && (i % 7 == 3)) begin
        in_valid = 1'b0;
        repeat (2) @(negedge sys_clk);
      end
      send_byte(8'(i), i == n - 1);
    end
    b = 0;
    while (ptr_q.size() == 0 && b < 200) begin
      @(negedge sys_clk);
      b++;
    end
    repeat (3) @(negedge sys_clk);
    exp_frames++;
    if (exp_ptr[15]) exp_trunc++;
    chk("wr_count", data_q.size(), exp_wr);
    mism = 0;
    for (int i = 0; i < data_q.size(); i++) begin
      e = (i < n) ? 8'(i) : 8'h00;
      if (data_q[i] !== e) mism++;
    end
    chk("data_content", mism, 0);
    chk("ptr_count", ptr_q.size(), 1);
    if (ptr_q.size() > 0) chk("ptr_word", ptr_q[0], exp_ptr);
    chk("ptr_after_data", int'(pcyc > last_dcyc), 1);
    chk("stat_frames", stat_frames, exp_frames);
    chk("stat_trunc", stat_trunc, exp_trunc);
  endtask

  initial begin
    bit seen;
    vecs[0] = '{100,  1'b1, 100,  16'h0064};
    vecs[1] = '{10,   1'b0, 60,   16'h003C};
    vecs[2] = '{1600, 1'b1, 1514, 16'h85EA};
    vecs[3] = '{1514, 1'b0, 1514, 16'h05EA};
    vecs[4] = '{60,   1'b0, 60,   16'h003C};
    vecs[5] = '{59,   1'b1, 60,   16'h003C};
    vecs[6] = '{1,    1'b0, 60,   16'h003C};
    vecs[7] = '{1515, 1'b0, 1514, 16'h85EA};
    vecs[8] = '{61,   1'b0, 61,   16'h003D};

    rst_sys = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    data_fifo_free = 12'd4095;
    ptr_fifo_full = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_data_wr", data_fifo_wr, 0);
    chk("rst_data_dout", data_fifo_dout, 0);
    chk("rst_ptr_wr", ptr_fifo_wr, 0);
    chk("rst_ptr_dout", ptr_fifo_dout, 0);
    chk("rst_stat_frames", stat_frames, 0);
    chk("rst_stat_trunc", stat_trunc, 0);
    rst_sys = 1'b0;

    foreach (vecs[k])
      run_frame(vecs[k].n, vecs[k].gap, vecs[k].exp_wr, vecs[k].exp_ptr);

    for (int s = 0; s < 2; s++) begin
      data_fifo_free = (s == 0) ? 12'd1000 : 12'd4095;
      ptr_fifo_full  = (s == 1);
      pulse_reset();
      data_q.delete();
      ptr_q.delete();
      seen = 1'b0;
      repeat (10) begin
        @(negedge sys_clk);
        if (in_ready) seen = 1'b1;
      end
      chk("stall_ready", int'(seen), 0);
      chk("stall_writes", data_q.size() + ptr_q.size(), 0);
      data_fifo_free = 12'd4095;
      ptr_fifo_full  = 1'b0;
      @(negedge sys_clk);
      chk("release_ready", in_ready, 1);
      run_frame(100, 1'b0, 100, 16'h0064);
    end

    pulse_reset();
    for (int i = 0; i < 30; i++) send_byte(8'(i), 1'b0);
    ptr_q.delete();
    rst_sys = 1'b1;
    @(negedge sys_clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_data_wr", data_fifo_wr, 0);
    chk("midrst_stat_frames", stat_frames, 0);
    rst_sys = 1'b0;
    repeat (5) @(negedge sys_clk);
    chk("midrst_no_ptr", ptr_q.size(), 0);
    run_frame(100, 1'b0, 100, 16'h0064);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
